// File: rtl/rxd_nibble_port.sv
// Pin-side nibble receiver: two-flop synchroniser, change debouncer and a small FIFO
// drained by the core through a valid/pop handshake, with a sticky overrun flag.
module rxd_nibble_port #(
   parameter int unsigned StableCyc = 4,
   parameter int unsigned Depth     = 4,
   parameter int unsigned CntW      = 3
) (
   input  logic            clk_i,
   input  logic            nreset_i,
   input  logic [3:0]      rxd_i,
   input  logic            rx_en_i,
   input  logic            rx_pop_i,
   input  logic            ovf_clr_i,
   output logic [3:0]      rx_data_o,
   output logic            rx_valid_o,
   output logic [CntW-1:0] rx_count_o,
   output logic            rx_ovf_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned WinW = (StableCyc > 1) ? $clog2(StableCyc) : 1;
   localparam logic [WinW-1:0] WinLast = WinW'(StableCyc - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(Depth);

   typedef enum logic [0:0] {StIdle, StSettle} state_e;

   state_e          state_q, state_d;
   logic [3:0]      s1_q, rxd_s_q;
   logic [3:0]      last_q, last_d;
   logic [3:0]      cand_q, cand_d;
   logic [WinW-1:0] win_q, win_d;
   logic [3:0]      mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            push, pop, full, push_ok, drop;

   // Debounce FSM: a candidate must hold for StableCyc samples before it is pushed.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cand_d  = cand_q;
      win_d   = win_q;
      push    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!rx_en_i) begin
               last_d = rxd_s_q;
            end else if (rxd_s_q != last_q) begin
               cand_d  = rxd_s_q;
               win_d   = '0;
               state_d = StSettle;
            end
         end
         StSettle: begin
            if (!rx_en_i) begin
               state_d = StIdle;
            end else if (rxd_s_q != cand_q) begin
               cand_d = rxd_s_q;
               win_d  = '0;
            end else if (win_q != WinLast) begin
               win_d = win_q + WinW'(1);
            end else begin
               last_d  = cand_q;
               push    = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      pop      = rx_pop_i && (count_q != '0);
      full     = (count_q == CntFull);
      push_ok  = push && (!full || pop);
      drop     = push && full && !pop;
      wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push_ok && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (!push_ok && pop) begin
         count_d = count_q - CntW'(1);
      end
      // A drop in the same cycle as a clear must remain visible.
      ovf_d = drop | (ovf_q & ~ovf_clr_i);
   end

   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         s1_q     <= '0;
         rxd_s_q  <= '0;
         state_q  <= StIdle;
         last_q   <= '0;
         cand_q   <= '0;
         win_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         s1_q     <= rxd_i;
         rxd_s_q  <= s1_q;
         state_q  <= state_d;
         last_q   <= last_d;
         cand_q   <= cand_d;
         win_q    <= win_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         if (push_ok) begin
            mem_q[wr_ptr_q] <= cand_q;
         end
      end
   end

   assign rx_data_o  = mem_q[rd_ptr_q];
   assign rx_valid_o = (count_q != '0);
   assign rx_count_o = count_q;
   assign rx_ovf_o   = ovf_q;

endmodule
